// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the register-file write-port arbiter.
// The master drives a request (valid/rd/data) and the slave answers with ready.
interface regfile_wb_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the ALU and load writeback sources that share the register file's single write port.
// It registers the winner onto the write port, drops writes to x0 and counts the cycles in which both sources requested.
module regfile_wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus,
    output logic               RegWrite,
    output logic [4:0]         Rd,
    output logic [31:0]        Write_data,
    output logic               last_grant,
    output logic [CNT_W-1:0]   conflict_cnt
);
    logic        both_valid;
    logic        any_valid;
    logic        grant_idx;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // The flops use the ungated grant because reset overrides them anyway.
    // Only the ready outputs are masked by rst, so no request is acknowledged while reset is high.
    always_comb begin
        both_valid     = bus.req0_valid && bus.req1_valid;
        any_valid      = bus.req0_valid || bus.req1_valid;
        grant_idx      = both_valid ? ~last_grant : bus.req1_valid;
        sel_rd         = grant_idx ? bus.req1_rd : bus.req0_rd;
        sel_data       = grant_idx ? bus.req1_data : bus.req0_data;
        bus.req0_ready = any_valid && !grant_idx && !rst;
        bus.req1_ready = any_valid && grant_idx && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite     <= 1'b0;
            Rd           <= 5'd0;
            Write_data   <= 32'd0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            RegWrite <= any_valid && (sel_rd != 5'd0);
            if (any_valid) begin
                Rd         <= sel_rd;
                Write_data <= sel_data;
                last_grant <= grant_idx;
            end
            if (both_valid && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32×32 register file. Two writeback sources share the file's single write port: requester 0 (ALU result) and requester 1 (load data from memory). The block grants one request per cycle using round-robin arbitration and registers the winner onto the register file's `RegWrite`/`Rd`/`Write_data` inputs. It also drops writes to x0 and counts arbitration collisions.

## Interface
Parameters:
- `CNT_W`, default 16: width of the collision counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req0_valid`, in, 1: ALU writeback request.
- `req0_rd`, in, 5: ALU destination register.
- `req0_data`, in, 32: ALU result.
- `req0_ready`, out, 1: request 0 accepted this cycle.
- `req1_valid`, in, 1: load writeback request.
- `req1_rd`, in, 5: load destination register.
- `req1_data`, in, 32: load data.
- `req1_ready`, out, 1: request 1 accepted this cycle.
- `RegWrite`, out, 1: register file write enable.
- `Rd`, out, 5: register file write address.
- `Write_data`, out, 32: register file write data.
- `last_grant`, out, 1: index of the most recently granted requester.
- `conflict_cnt`, out, CNT_W: saturating count of cycles in which both requests were valid.

## Operation
- A transfer on port i happens when `reqi_valid && reqi_ready` is true at a rising edge.
- Requesters hold `valid`, `rd` and `data` stable until the transfer. `valid` must not depend on `ready`.
- Grant logic is combinational from the valid inputs and `last_grant`:
  - Neither request valid: no grant, both ready outputs 0.
  - Exactly one request valid: grant it.
  - Both requests valid: grant `~last_grant`, i.e. strict alternation.
- `reqi_ready` equals grant i. At most one ready output is high in any cycle.
- On a grant, `last_grant` takes the granted index. With no grant, `last_grant` holds its value.
- Output register, loaded at every edge:
  - `RegWrite <= grant && (granted rd != 0)`.
  - `Rd` and `Write_data` take the granted rd and data.
  - With no grant, `RegWrite <= 0`, and `Rd` and `Write_data` hold their previous values.
- x0 requests are handled normally: they are accepted (ready=1), take the slot and update `last_grant`, but produce `RegWrite=0`.
- `conflict_cnt` increments by 1 in every cycle with `req0_valid && req1_valid`, whatever the grant. It saturates at 2^CNT_W−1 and never wraps.
- Both requests valid with the same rd: they are serviced on consecutive cycles in round-robin order. The register file ends up holding the data of the request granted second.
- There is no backpressure from the register file. Sustained throughput is one write per cycle.

## Timing
- Reset (asynchronous assert):
  - Registered outputs clear immediately: `RegWrite=0`, `Rd=0`, `Write_data=0`, `conflict_cnt=0`.
  - `last_grant=1`, so requester 0 wins the first tie.
- While `rst` is high, `req0_ready=req1_ready=0` and no transfer occurs.
- Reset release is synchronous to `clk`. Arbitration resumes at the first edge with `rst` low.
- Reset mid-operation: any request granted in the same cycle is lost. Requesters re-present it after reset.
- Latency:
  - Request accepted at edge N.
  - `RegWrite`, `Rd` and `Write_data` are valid during cycle N+1.
  - The register file commits at edge N+1.
  - A read of the same register returns the new value from cycle N+1 after edge N+1, i.e. two edges after the request was presented.
- Ready is combinational in the request cycle, with no cycle of delay. This gives zero bubbles between back-to-back grants.
- With both requests continuously valid, grants alternate 0,1,0,1… and each requester gets exactly 50% of cycles.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle with both requests valid -> `RegWrite=0`, `Rd=0`, `Write_data=0`, `conflict_cnt=0`, `last_grant=1`, both ready 0 while `rst=1`.
- **Single request:** `req0` with rd=3, data=A5A5A5A5 for one cycle -> `req0_ready=1` that cycle; next cycle `RegWrite=1`, `Rd=3`, `Write_data=A5A5A5A5`; a register file read of R3 afterwards returns A5A5A5A5.
- **Tie after reset:**
  - Stimulus: `req0` (rd=5, data=11111111) and `req1` (rd=6, data=22222222) both valid.
  - Grants: `req0` at the first edge, `req1` at the second.
  - Outputs: `RegWrite` high for two consecutive cycles, first with `Rd`=5 then `Rd`=6.
  - `conflict_cnt` ends at 1.
- **Same-rd tie:** both valid with rd=7 (`req0` data=1, `req1` data=2), `last_grant=1` -> R7 = 00000002 after both commit.
- **x0 drop:** `req1` with rd=0, data=FFFFFFFF -> `req1_ready=1`, `last_grant=1`, `RegWrite` stays 0, R0 reads 0.
- **Saturation and fairness:** CNT_W=4, both requests held valid for 20 cycles -> grants strictly alternate (10 each), `conflict_cnt` stops at 15.
